decoder_scan: RTL and testbench

Registered, parametrised binary-to-one-hot decoder with a built-in scan mode. In direct mode it decodes a validated `IN_W`-bit code into a `2**IN_W`-line one-hot output. In scan mode it walks the one-hot output through every line at a programmable rate. It sits between control logic and multiplexed board outputs such as LED rows and seven-segment digit selects, and replaces the fixed 2-bit combinational decoders used so far.

---
 rtl/decoder_scan_if.sv | 24 ++
 rtl/decoder_scan.sv | 74 +++++++
 tb/tb_decoder_scan.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/decoder_scan_if.sv
// Bundle between a sequencing controller and the decoder_scan line driver.
// The controller owns the master side; the decoder owns the slave side.
interface decoder_scan_if #(
    parameter int IN_W = 2
) ();
    logic                   i_en;
    logic                   i_mode;
    logic                   i_blank;
    logic [IN_W-1:0]        i_in;
    logic                   i_in_valid;
    logic [(1<<IN_W)-1:0]   o_out;
    logic                   o_out_valid;
    logic [IN_W-1:0]        o_idx;

    modport master (
        output i_en, i_mode, i_blank, i_in, i_in_valid,
        input  o_out, o_out_valid, o_idx
    );

    modport slave (
        input  i_en, i_mode, i_blank, i_in, i_in_valid,
        output o_out, o_out_valid, o_idx
    );
endinterface

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with a prescaled scan mode that walks
// the selected line across all outputs (LED rows, digit selects).
module decoder_scan #(
    parameter int IN_W       = 2,
    parameter int DIV        = 4,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    decoder_scan_if.slave   bus
);
    localparam int OUT_W = 1 << IN_W;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [IN_W-1:0]  r_idx;
    logic [PRE_W-1:0] r_pre;
    logic             r_mode_q;
    logic             r_sel;
    logic             r_blank;
    logic             r_out_valid;
    logic [OUT_W-1:0] w_onehot;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_idx       <= '0;
            r_pre       <= '0;
            r_mode_q    <= 1'b0;
            r_sel       <= 1'b0;
            r_blank     <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (!bus.i_en) begin
            r_out_valid <= 1'b0;
        end else begin
            // mode_q only tracks enabled cycles so a toggle during a stall
            // is still seen as a transition once enable returns
            r_mode_q <= bus.i_mode;
            r_blank  <= bus.i_blank;
            if (!bus.i_mode) begin
                r_out_valid <= 1'b0;
                if (bus.i_in_valid) begin
                    r_idx       <= bus.i_in;
                    r_sel       <= 1'b1;
                    r_pre       <= '0;
                    r_out_valid <= 1'b1;
                end
            end else if (!r_mode_q) begin
                r_idx       <= '0;
                r_pre       <= '0;
                r_sel       <= 1'b1;
                r_out_valid <= 1'b1;
            end else if (r_pre == PRE_LAST) begin
                // index width is exactly log2(OUT_W), so overflow is the wrap
                r_pre       <= '0;
                r_idx       <= r_idx + IN_W'(1);
                r_out_valid <= 1'b1;
            end else begin
                r_pre       <= r_pre + PRE_W'(1);
                r_out_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        w_onehot = '0;
        if (r_sel && !r_blank) begin
            w_onehot = OUT_W'(1) << r_idx;
        end
    end

    assign bus.o_out       = ACTIVE_LOW ? ~w_onehot : w_onehot;
    assign bus.o_out_valid = r_out_valid;
    assign bus.o_idx       = r_idx;
endmodule

// File: tb/tb_decoder_scan.sv
// Directed bench for decoder_scan: four instances cover the default build,
// active-low polarity, the 1-bit/DIV=1 corner and the 5-bit width.
module tb_decoder_scan;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    decoder_scan_if #(.IN_W(2)) ifa ();
    decoder_scan_if #(.IN_W(2)) ifb ();
    decoder_scan_if #(.IN_W(1)) ifc ();
    decoder_scan_if #(.IN_W(5)) ifd ();

    decoder_scan #(.IN_W(2), .DIV(4), .ACTIVE_LOW(1'b0)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    decoder_scan #(.IN_W(2), .DIV(4), .ACTIVE_LOW(1'b1)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));
    decoder_scan #(.IN_W(1), .DIV(1), .ACTIVE_LOW(1'b0)) dut_c (.i_clk(clk), .i_rst(rst), .bus(ifc));
    decoder_scan #(.IN_W(5), .DIV(4), .ACTIVE_LOW(1'b0)) dut_d (.i_clk(clk), .i_rst(rst), .bus(ifd));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [3:0] exp_out,
                         input logic exp_ov, input logic [1:0] exp_idx);
        checks++;
        if (ifa.o_out !== exp_out || ifa.o_out_valid !== exp_ov || ifa.o_idx !== exp_idx) begin
            failures++;
            $display("FAIL %s: got out=%b ov=%b idx=%0d, expected out=%b ov=%b idx=%0d",
                     name, ifa.o_out, ifa.o_out_valid, ifa.o_idx, exp_out, exp_ov, exp_idx);
        end
    endtask

    task automatic test_reset();
        ifa.i_en = 1; ifa.i_mode = 0; ifa.i_blank = 0; ifa.i_in = 2'd3; ifa.i_in_valid = 1;
        ifb.i_en = 1; ifb.i_mode = 0; ifb.i_blank = 0; ifb.i_in = 2'd3; ifb.i_in_valid = 1;
        ifc.i_en = 1; ifc.i_mode = 0; ifc.i_blank = 0; ifc.i_in = 1'b0; ifc.i_in_valid = 0;
        ifd.i_en = 1; ifd.i_mode = 0; ifd.i_blank = 0; ifd.i_in = 5'd0; ifd.i_in_valid = 0;
        rst = 1;
        step();
        step();
        chk_a("reset_a", 4'b0000, 1'b0, 2'd0);
        checks++;
        if (ifb.o_out !== 4'b1111 || ifb.o_out_valid !== 1'b0 || ifb.o_idx !== 2'd0) begin
            failures++;
            $display("FAIL reset_active_low: got out=%b ov=%b idx=%0d, expected out=1111 ov=0 idx=0",
                     ifb.o_out, ifb.o_out_valid, ifb.o_idx);
        end
        ifa.i_in_valid = 0;
        ifb.i_in_valid = 0;
        rst = 0;
    endtask

    task automatic test_direct();
        logic [3:0] exp_out;
        for (int k = 0; k < 4; k++) begin
            ifa.i_in = 2'(k);
            ifa.i_in_valid = 1;
            step();
            exp_out = 4'b0001 << k;
            chk_a("direct_decode", exp_out, 1'b1, 2'(k));
        end
        ifa.i_in_valid = 0;
        step();
        chk_a("direct_hold", 4'b1000, 1'b0, 2'd3);
        step();
        chk_a("direct_hold2", 4'b1000, 1'b0, 2'd3);
    endtask

    task automatic test_active_low();
        ifb.i_in = 2'd2;
        ifb.i_in_valid = 1;
        step();
        ifb.i_in_valid = 0;
        checks++;
        if (ifb.o_out !== 4'b1011 || ifb.o_out_valid !== 1'b1) begin
            failures++;
            $display("FAIL active_low_decode: got out=%b ov=%b, expected out=1011 ov=1",
                     ifb.o_out, ifb.o_out_valid);
        end
    endtask

    task automatic test_scan();
        logic [1:0] e_idx;
        ifa.i_mode = 1;
        ifa.i_in_valid = 0;
        step();
        chk_a("scan_entry", 4'b0001, 1'b1, 2'd0);
        for (int c = 1; c <= 16; c++) begin
            // stray codes during scan must be ignored
            ifa.i_in = 2'd2;
            ifa.i_in_valid = (c % 3 == 0);
            step();
            e_idx = 2'((c / 4) % 4);
            chk_a("scan_wrap", 4'b0001 << e_idx, (c % 4 == 0), e_idx);
        end
        ifa.i_in_valid = 0;
    endtask

    task automatic test_stall_blank();
        for (int c = 1; c <= 4; c++) step();
        chk_a("stall_at_idx1", 4'b0010, 1'b1, 2'd1);
        step();
        ifa.i_en = 0;
        for (int c = 0; c < 5; c++) begin
            step();
            chk_a("stall_frozen", 4'b0010, 1'b0, 2'd1);
        end
        ifa.i_en = 1;
        step();
        step();
        chk_a("stall_stretched", 4'b0010, 1'b0, 2'd1);
        step();
        chk_a("stall_step_idx2", 4'b0100, 1'b1, 2'd2);
        ifa.i_blank = 1;
        for (int k = 1; k <= 6; k++) begin
            step();
            chk_a("blank_running", 4'b0000, (k == 4), (k < 4) ? 2'd2 : 2'd3);
        end
        ifa.i_blank = 0;
        step();
        chk_a("blank_release", 4'b1000, 1'b0, 2'd3);
        step();
        chk_a("blank_wrap", 4'b0001, 1'b1, 2'd0);
    endtask

    task automatic test_rst_mode_exit();
        for (int c = 1; c <= 8; c++) step();
        chk_a("pre_reset_idx2", 4'b0100, 1'b1, 2'd2);
        rst = 1;
        step();
        rst = 0;
        chk_a("reset_mid_scan", 4'b0000, 1'b0, 2'd0);
        step();
        chk_a("scan_reentry", 4'b0001, 1'b1, 2'd0);
        for (int c = 1; c <= 12; c++) step();
        chk_a("scan_idx3", 4'b1000, 1'b1, 2'd3);
        ifa.i_mode = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_a("exit_hold", 4'b1000, 1'b0, 2'd3);
        end
        ifa.i_in = 2'd1;
        ifa.i_in_valid = 1;
        step();
        ifa.i_in_valid = 0;
        chk_a("exit_new_code", 4'b0010, 1'b1, 2'd1);
    endtask

    task automatic test_mode_priority();
        ifa.i_mode = 1;
        ifa.i_in = 2'd3;
        ifa.i_in_valid = 1;
        step();
        chk_a("prio_scan_wins", 4'b0001, 1'b1, 2'd0);
        ifa.i_mode = 0;
        step();
        chk_a("prio_direct_wins", 4'b1000, 1'b1, 2'd3);
        ifa.i_en = 0;
        ifa.i_in = 2'd2;
        step();
        chk_a("en_freeze_direct", 4'b1000, 1'b0, 2'd3);
        ifa.i_en = 1;
        ifa.i_in_valid = 0;
    endtask

    task automatic test_edge_div1();
        logic [1:0] exp_out;
        ifc.i_mode = 1;
        for (int j = 0; j < 6; j++) begin
            step();
            exp_out = (j % 2 == 0) ? 2'b01 : 2'b10;
            checks++;
            if (ifc.o_out !== exp_out || ifc.o_out_valid !== 1'b1) begin
                failures++;
                $display("FAIL div1_scan j=%0d: got out=%b ov=%b, expected out=%b ov=1",
                         j, ifc.o_out, ifc.o_out_valid, exp_out);
            end
        end
    endtask

    task automatic test_edge_wide();
        ifd.i_in = 5'd31;
        ifd.i_in_valid = 1;
        step();
        checks++;
        if (ifd.o_out !== 32'h8000_0000 || ifd.o_out_valid !== 1'b1 || ifd.o_idx !== 5'd31) begin
            failures++;
            $display("FAIL wide_in31: got out=%h ov=%b idx=%0d, expected out=80000000 ov=1 idx=31",
                     ifd.o_out, ifd.o_out_valid, ifd.o_idx);
        end
        ifd.i_in = 5'd5;
        step();
        ifd.i_in_valid = 0;
        checks++;
        if (ifd.o_out !== 32'h0000_0020 || ifd.o_idx !== 5'd5) begin
            failures++;
            $display("FAIL wide_in5: got out=%h idx=%0d, expected out=00000020 idx=5",
                     ifd.o_out, ifd.o_idx);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1;
        test_reset();
        test_direct();
        test_active_low();
        test_scan();
        test_stall_blank();
        test_rst_mode_exit();
        test_mode_priority();
        test_edge_div1();
        test_edge_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
